// File: rtl/obuf_tag_sched_if.sv
// Handshake bundle between the output-buffer tag scheduler and its producer/consumer stages.
interface obuf_tag_sched_if #(
    parameter int unsigned TAG_W = 1
);
    logic             tag_req;
    logic             tag_ready;
    logic [TAG_W-1:0] tag_id;
    logic             tag_flush;
    logic             ldmem_tag_done;
    logic             ldmem_tag_ready;
    logic [TAG_W-1:0] ldmem_tag;
    logic             compute_tag_done;
    logic             compute_tag_ready;
    logic [TAG_W-1:0] compute_tag;
    logic             stmem_tag_done;
    logic             stmem_tag_ready;
    logic [TAG_W-1:0] stmem_tag;
    logic [TAG_W:0]   free_count;

    modport slave (
        input  tag_req, tag_flush, ldmem_tag_done, compute_tag_done, stmem_tag_done,
        output tag_ready, tag_id, ldmem_tag_ready, ldmem_tag, compute_tag_ready,
               compute_tag, stmem_tag_ready, stmem_tag, free_count
    );

    modport master (
        output tag_req, tag_flush, ldmem_tag_done, compute_tag_done, stmem_tag_done,
        input  tag_ready, tag_id, ldmem_tag_ready, ldmem_tag, compute_tag_ready,
               compute_tag, stmem_tag_ready, stmem_tag, free_count
    );
endinterface

// File: rtl/obuf_tag_sched.sv
// Rotating output-buffer tag scheduler: each tag walks FREE->LDMEM->COMPUTE->(STMEM)->FREE
// in strict pointer order, with compute passes repeating until the tag is flushed.
module obuf_tag_sched #(
    parameter int unsigned NUM_TAGS      = 2,
    parameter int unsigned TAG_W         = 1,
    parameter bit          STORE_ENABLED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    obuf_tag_sched_if.slave   bus
);

    localparam int unsigned CNT_W = TAG_W + 1;

    localparam logic [1:0] ST_FREE    = 2'd0;
    localparam logic [1:0] ST_LDMEM   = 2'd1;
    localparam logic [1:0] ST_COMPUTE = 2'd2;
    localparam logic [1:0] ST_STMEM   = 2'd3;

    logic [1:0]          r_state [NUM_TAGS];
    logic [NUM_TAGS-1:0] r_flush;
    logic [TAG_W-1:0]    r_alloc_ptr;
    logic [TAG_W-1:0]    r_ldmem_ptr;
    logic [TAG_W-1:0]    r_compute_ptr;
    logic [TAG_W-1:0]    r_stmem_ptr;

    logic [1:0]          w_state_nxt [NUM_TAGS];
    logic [NUM_TAGS-1:0] w_flush_nxt;
    logic [TAG_W-1:0]    w_alloc_ptr_nxt;
    logic [TAG_W-1:0]    w_ldmem_ptr_nxt;
    logic [TAG_W-1:0]    w_compute_ptr_nxt;
    logic [TAG_W-1:0]    w_stmem_ptr_nxt;

    logic                w_tag_ready;
    logic                w_ldmem_ready;
    logic                w_compute_ready;
    logic                w_stmem_ready;
    logic                w_alloc_hs;
    logic                w_ldmem_hs;
    logic                w_compute_hs;
    logic                w_stmem_hs;
    logic [TAG_W-1:0]    w_flush_tgt;
    logic                w_flush_hit;
    logic                w_compute_flush;
    logic [CNT_W-1:0]    w_free_cnt;

    assign w_tag_ready     = (r_state[r_alloc_ptr]   == ST_FREE);
    assign w_ldmem_ready   = (r_state[r_ldmem_ptr]   == ST_LDMEM);
    assign w_compute_ready = (r_state[r_compute_ptr] == ST_COMPUTE);
    assign w_stmem_ready   = (r_state[r_stmem_ptr]   == ST_STMEM);

    assign w_alloc_hs   = bus.tag_req          && w_tag_ready;
    assign w_ldmem_hs   = bus.ldmem_tag_done   && w_ldmem_ready;
    assign w_compute_hs = bus.compute_tag_done && w_compute_ready;
    assign w_stmem_hs   = bus.stmem_tag_done   && w_stmem_ready;

    // Flush always names the most recently allocated tag; a same-cycle flush counts for the compute done.
    assign w_flush_tgt     = r_alloc_ptr - TAG_W'(1);
    assign w_flush_hit     = bus.tag_flush && (r_state[w_flush_tgt] != ST_FREE);
    assign w_compute_flush = r_flush[r_compute_ptr] ||
                             (w_flush_hit && (w_flush_tgt == r_compute_ptr));

    // Next-state: each handshake owns a distinct tag, so the updates never collide.
    always_comb begin
        w_state_nxt       = r_state;
        w_flush_nxt       = r_flush;
        w_alloc_ptr_nxt   = r_alloc_ptr;
        w_ldmem_ptr_nxt   = r_ldmem_ptr;
        w_compute_ptr_nxt = r_compute_ptr;
        w_stmem_ptr_nxt   = r_stmem_ptr;

        if (w_flush_hit) begin
            w_flush_nxt[w_flush_tgt] = 1'b1;
        end
        if (w_alloc_hs) begin
            w_state_nxt[r_alloc_ptr] = ST_LDMEM;
            w_flush_nxt[r_alloc_ptr] = 1'b0;
            w_alloc_ptr_nxt          = r_alloc_ptr + TAG_W'(1);
        end
        if (w_ldmem_hs) begin
            w_state_nxt[r_ldmem_ptr] = ST_COMPUTE;
            w_ldmem_ptr_nxt          = r_ldmem_ptr + TAG_W'(1);
        end
        if (w_compute_hs && w_compute_flush) begin
            w_state_nxt[r_compute_ptr] = STORE_ENABLED ? ST_STMEM : ST_FREE;
            w_flush_nxt[r_compute_ptr] = 1'b0;
            w_compute_ptr_nxt          = r_compute_ptr + TAG_W'(1);
        end
        if (w_stmem_hs) begin
            w_state_nxt[r_stmem_ptr] = ST_FREE;
            w_stmem_ptr_nxt          = r_stmem_ptr + TAG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_TAGS; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_flush       <= '0;
            r_alloc_ptr   <= '0;
            r_ldmem_ptr   <= '0;
            r_compute_ptr <= '0;
            r_stmem_ptr   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_flush       <= w_flush_nxt;
            r_alloc_ptr   <= w_alloc_ptr_nxt;
            r_ldmem_ptr   <= w_ldmem_ptr_nxt;
            r_compute_ptr <= w_compute_ptr_nxt;
            r_stmem_ptr   <= w_stmem_ptr_nxt;
        end
    end

    always_comb begin
        w_free_cnt = '0;
        for (int unsigned i = 0; i < NUM_TAGS; i++) begin
            if (r_state[i] == ST_FREE) begin
                w_free_cnt = w_free_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.tag_ready         = w_tag_ready;
    assign bus.tag_id            = r_alloc_ptr;
    assign bus.ldmem_tag_ready   = w_ldmem_ready;
    assign bus.ldmem_tag         = r_ldmem_ptr;
    assign bus.compute_tag_ready = w_compute_ready;
    assign bus.compute_tag       = r_compute_ptr;
    assign bus.stmem_tag_ready   = w_stmem_ready;
    assign bus.stmem_tag         = r_stmem_ptr;
    assign bus.free_count        = w_free_cnt;

endmodule

// File: doc/obuf_tag_sched.md
OBUF_TAG_SCHED -- requirements
Module: obuf_tag_sched

Interface
REQ-001 SHALL have parameter NUM_TAGS, default 2: number of output-buffer tags in rotation; legal values are 2 and 4.
REQ-002 SHALL have parameter TAG_W, default 1: tag index width, equal to log2(NUM_TAGS).
REQ-003 SHALL have parameter STORE_ENABLED, default 1: 1 = a flushed tag goes to store, 0 = a flushed tag is freed directly.
REQ-004 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have tag_req, input, 1: request to allocate the next tag.
REQ-007 SHALL have tag_ready, output, 1: the tag at alloc_ptr is FREE.
REQ-008 SHALL have tag_id, output, TAG_W: equal to alloc_ptr.
REQ-009 SHALL have tag_flush, input, 1: mark the last allocated tag for flush.
REQ-010 SHALL have ldmem_tag_done, input, 1: the load for ldmem_tag has completed.
REQ-011 SHALL have ldmem_tag_ready, output, 1: the tag at ldmem_ptr is in LDMEM.
REQ-012 SHALL have ldmem_tag, output, TAG_W: equal to ldmem_ptr.
REQ-013 SHALL have compute_tag_done, input, 1: one compute pass on compute_tag has completed.
REQ-014 SHALL have compute_tag_ready, output, 1: the tag at compute_ptr is in COMPUTE.
REQ-015 SHALL have compute_tag, output, TAG_W: equal to compute_ptr.
REQ-016 SHALL have stmem_tag_done, input, 1: the store for stmem_tag has completed.
REQ-017 SHALL have stmem_tag_ready, output, 1: the tag at stmem_ptr is in STMEM.
REQ-018 SHALL have stmem_tag, output, TAG_W: equal to stmem_ptr.
REQ-019 SHALL have free_count, output, TAG_W+1: number of tags currently FREE.

Function
REQ-020 SHALL hold, per tag, a 2-bit state (FREE=0, LDMEM=1, COMPUTE=2, STMEM=3) and a flush flag.
REQ-021 SHALL hold four TAG_W-bit pointers (alloc, ldmem, compute, stmem); each increments modulo NUM_TAGS and wraps from NUM_TAGS-1 to 0.
REQ-022 SHALL drive all ready outputs, tag indices and free_count combinationally from registered state only, with no input-to-output combinational path.
REQ-023 SHALL accept a handshake on the clock edge where a done/req input and its matching ready are both 1; the new state is visible one cycle later.
REQ-024 SHALL ignore any done/req input when its matching ready is 0, with no state change.
REQ-025 On tag_req && tag_ready: state[alloc_ptr] SHALL go FREE->LDMEM, its flush flag SHALL clear, and alloc_ptr SHALL increment.
REQ-026 On ldmem_tag_done && ldmem_tag_ready: state[ldmem_ptr] SHALL go LDMEM->COMPUTE and ldmem_ptr SHALL increment.
REQ-027 On tag_flush: the flush flag of tag (alloc_ptr-1 mod NUM_TAGS) SHALL set if that tag is not FREE; otherwise tag_flush SHALL be ignored.
REQ-028 On compute_tag_done && compute_tag_ready with flush flag clear: the tag SHALL stay in COMPUTE (reuse) and compute_ptr SHALL not move.
REQ-029 On compute_tag_done && compute_tag_ready with flush flag set: the tag SHALL go to STMEM (STORE_ENABLED=1) or FREE (STORE_ENABLED=0), its flag SHALL clear, and compute_ptr SHALL increment.
REQ-030 When tag_flush targets the current compute tag in the same cycle as compute_tag_done, the flush SHALL take effect on that done (REQ-029 path).
REQ-031 On stmem_tag_done && stmem_tag_ready: the tag SHALL go STMEM->FREE and stmem_ptr SHALL increment.
REQ-032 SHALL process simultaneous handshakes on different tags in the same cycle independently; free_count SHALL reflect the net change (e.g. one alloc plus one release leaves it unchanged).
REQ-033 SHALL never skip a tag: allocation, load, compute and store all proceed in strict pointer order.

Reset
REQ-034 While reset=1, asynchronously, all tag states SHALL be FREE, all flags 0 and all pointers 0, giving: tag_ready=1, ldmem/compute/stmem_ready=0, all indices 0, free_count=NUM_TAGS.
REQ-035 Reset asserted mid-operation SHALL abandon all in-flight tags with no pending handshake completing; the first post-reset tag_req SHALL allocate tag 0.

Verification
REQ-036 Basic flow (NUM_TAGS=2): tag_req, ldmem_done, tag_flush, compute_done, stmem_done -> tag 0 walks FREE->LDMEM->COMPUTE->STMEM->FREE, one cycle per step; free_count goes 2,1,...,2.
REQ-037 Full: two tag_req with no done -> tag_ready=0, free_count=0; a third tag_req is ignored; alloc_ptr wraps to 0.
REQ-038 Reuse: three compute_done with no flush -> compute_tag_ready stays 1 and compute_tag=0; a flush then a done -> stmem_tag_ready=1.
REQ-039 Simultaneous: tag_flush and compute_done in the same cycle on tag 0 -> tag 0 reaches STMEM next cycle; with STORE_ENABLED=0 it reaches FREE instead.
REQ-040 Overlap: in one cycle, stmem_done on tag 0 and tag_req for tag 0 while tag 1 is in COMPUTE -> the store is accepted; the request is accepted the next cycle, with free_count 0->1->0.
REQ-041 Reset with both tags busy -> next cycle free_count=2 and all indices 0; a stray stmem_done right after reset is ignored.
